// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) that
// presents four registered BCD digits, saturating to 9999 when the input exceeds it.
module bin_to_bcd_seq #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       digito1,
  output logic [3:0]       digito2,
  output logic [3:0]       digito3,
  output logic [3:0]       digito4
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

  state_t              state;
  logic [WIDTH-1:0]    shreg;
  logic [15:0]         bcd;
  logic [15:0]         bcd_adj;
  logic [CW-1:0]       cnt;
  logic                ovf;
  logic [16+WIDTH-1:0] shifted;

  // Add-3 correction is strictly per nibble; no carry crosses a digit boundary.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted = {bcd_adj, shreg} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      digito1  <= 4'd0;
      digito2  <= 4'd0;
      digito3  <= 4'd0;
      digito4  <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= bin;
            bcd   <= '0;
            ovf   <= (32'(bin) > 32'd9999);
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          bcd   <= shifted[16+WIDTH-1:WIDTH];
          shreg <= shifted[WIDTH-1:0];
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= LATCH;
          end
        end
        LATCH: begin
          // Values above 9999 have lost digits in the accumulator, so show 9999 instead.
          if (ovf) begin
            digito1 <= 4'd9;
            digito2 <= 4'd9;
            digito3 <= 4'd9;
            digito4 <= 4'd9;
          end else begin
            digito1 <= bcd[3:0];
            digito2 <= bcd[7:4];
            digito3 <= bcd[11:8];
            digito4 <= bcd[15:12];
          end
          overflow <= ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: random and boundary values against a
// decimal-arithmetic reference, plus latency, throughput and reset scenarios.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy, done, overflow;
  logic [3:0]  digito1, digito2, digito3, digito4;
  logic [16:0] obs;

  int tests = 0;
  int fails = 0;

  bin_to_bcd_seq #(.WIDTH(14)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .overflow(overflow),
    .digito1(digito1), .digito2(digito2), .digito3(digito3), .digito4(digito4)
  );

  always #5 clk = ~clk;

  assign obs = {overflow, digito4, digito3, digito2, digito1};

  // Expected {overflow, thousands, hundreds, tens, units} from plain decimal arithmetic.
  function automatic logic [16:0] model(input int v);
    if (v > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic start_conv(input int v);
    @(negedge clk);
    start = 1'b1;
    bin   = 14'(v);
    @(negedge clk);
    start = 1'b0;
    bin   = 14'($urandom);
  endtask

  // Waits (bounded) for done; reports cycles taken and whether busy/outputs behaved meanwhile.
  task automatic wait_done(input logic [16:0] prev, output int n, output bit busy_ok,
                           output bit held_ok);
    n = 0; busy_ok = 1'b1; held_ok = 1'b1;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (obs !== prev) held_ok = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    int n; bit b_ok, h_ok;
    #3;
    tests++;
    if ({obs, busy, done} !== 19'd0) begin
      fails++;
      $display("[TB] FAIL reset_initial: got %h busy=%b done=%b, want all zero", obs, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    start_conv(12000);
    wait_done(17'd0, n, b_ok, h_ok);
    start_conv(777);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({obs, busy, done} !== 19'd0) begin
      fails++;
      $display("[TB] FAIL reset_async: got %h busy=%b done=%b, want all zero", obs, busy, done);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic_1234;
    int n; bit b_ok, h_ok;
    start_conv(1234);
    wait_done(17'd0, n, b_ok, h_ok);
    tests++;
    if (n !== 15) begin
      fails++; $display("[TB] FAIL basic_latency: got %0d cycles, want 15", n);
    end
    tests++;
    if (!b_ok || !h_ok) begin
      fails++; $display("[TB] FAIL basic_during: busy_ok=%b digits_held=%b, want 1 1", b_ok, h_ok);
    end
    tests++;
    if ({obs, busy} !== {17'h01234, 1'b0}) begin
      fails++; $display("[TB] FAIL basic_result: got %h busy=%b, want 01234 busy=0", obs, busy);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("[TB] FAIL basic_done_pulse: got done=%b, want 0", done);
    end
  endtask

  task automatic test_boundaries;
    int vals[6] = '{0, 9999, 8, 5, 10000, 42};
    int n; bit b_ok, h_ok;
    logic [16:0] prev;
    foreach (vals[i]) begin
      prev = obs;
      start_conv(vals[i]);
      wait_done(prev, n, b_ok, h_ok);
      tests++;
      if (n !== 15 || !b_ok || !h_ok || obs !== model(vals[i])) begin
        fails++;
        $display("[TB] FAIL boundary_%0d: got %h lat=%0d busy_ok=%b held=%b, want %h lat=15",
                 vals[i], obs, n, b_ok, h_ok, model(vals[i]));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    int v, n; bit b_ok, h_ok;
    logic [16:0] prev;
    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 16383));
      prev = obs;
      start_conv(v);
      wait_done(prev, n, b_ok, h_ok);
      tests++;
      if (n !== 15 || !b_ok || !h_ok || obs !== model(v)) begin
        fails++;
        $display("[TB] FAIL random_%0d: got %h lat=%0d busy_ok=%b held=%b, want %h lat=15",
                 v, obs, n, b_ok, h_ok, model(v));
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0) begin
        fails++; $display("[TB] FAIL random_done_pulse: got done=%b, want 0", done);
      end
    end
  endtask

  // start held high: accepts on edges 0,16,32,48, each done 15 edges later.
  task automatic test_back_to_back;
    logic [13:0] hist[64];
    int k;
    bit exp_done;
    for (int i = 0; i <= 64; i++) begin
      @(negedge clk);
      if (i > 0) begin
        k = i - 1;
        exp_done = (k % 16 == 15);
        tests++;
        if (done !== exp_done || busy !== !exp_done) begin
          fails++;
          $display("[TB] FAIL b2b_flags_edge%0d: got done=%b busy=%b, want done=%b busy=%b",
                   k, done, busy, exp_done, !exp_done);
        end
        if (exp_done) begin
          tests++;
          if (obs !== model(int'(hist[k-15]))) begin
            fails++;
            $display("[TB] FAIL b2b_result_edge%0d: got %h, want %h", k, obs,
                     model(int'(hist[k-15])));
          end
        end
      end
      if (i < 64) begin
        start = 1'b1;
        bin = 14'($urandom);
        hist[i] = bin;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midconv;
    int n; bit b_ok, h_ok, saw_done;
    start_conv(5678);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({obs, busy, done} !== 19'd0) begin
      fails++; $display("[TB] FAIL midreset_clear: got %h busy=%b, want zero", obs, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    tests++;
    if (saw_done !== 1'b0 || obs !== 17'd0) begin
      fails++; $display("[TB] FAIL midreset_no_done: got activity=%b digits=%h, want 0 0", saw_done, obs);
    end
    start_conv(5678);
    wait_done(17'd0, n, b_ok, h_ok);
    tests++;
    if (n !== 15 || !b_ok || !h_ok || obs !== 17'h05678) begin
      fails++;
      $display("[TB] FAIL midreset_restart: got %h lat=%0d busy_ok=%b held=%b, want 05678 lat=15",
               obs, n, b_ok, h_ok);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin = '0;
    test_reset();
    test_basic_1234();
    test_boundaries();
    test_random();
    test_back_to_back();
    test_reset_midconv();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
